// File: rtl/reg_spill_ram.sv
// Backing store for the upper register half (x16..x31): 16x32 single-port array
// that serializes the rs1 read, rs2 read and rd write of each request through one FSM.
module reg_spill_ram #(
    parameter int unsigned RD_LAT = 2,
    parameter logic [31:0] INIT_B = 32'd16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        prog_mode,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd_a,
    input  logic        req_rd_b,
    input  logic        req_we,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata1,
    output logic [31:0] rsp_rdata2,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        RESP
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] mem [16];
    logic [2:0]  cnt;
    logic        cap_rd_a;
    logic        cap_rd_b;
    logic        cap_we;
    logic [4:0]  cap_rs1;
    logic [4:0]  cap_rs2;
    logic [4:0]  cap_rd;
    logic [31:0] cap_wdata;
    logic        accept;
    logic        stage_done;
    logic        load_cnt;
    logic        req_err;

    assign accept     = req_valid && req_ready && !prog_mode;
    assign stage_done = (cnt == 3'd0);
    assign load_cnt   = ((next_state == RD_A) && (state != RD_A)) ||
                        ((next_state == RD_B) && (state != RD_B));
    assign req_err    = (req_rd_a && !req_rs1[4]) ||
                        (req_rd_b && !req_rs2[4]) ||
                        (req_we   && !req_rd[4]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_rd_a)      next_state = RD_A;
                    else if (req_rd_b) next_state = RD_B;
                    else if (req_we)   next_state = WR;
                    else               next_state = RESP;
                end
            end
            RD_A: begin
                if (stage_done) begin
                    if (cap_rd_b)    next_state = RD_B;
                    else if (cap_we) next_state = WR;
                    else             next_state = RESP;
                end
            end
            RD_B: begin
                if (stage_done) begin
                    if (cap_we) next_state = WR;
                    else        next_state = RESP;
                end
            end
            WR: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (prog_mode) next_state = IDLE;
    end

    // Handshake/status flags are registered from next_state so they track the FSM without
    // any combinational path from the request or response inputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
            cnt        <= '0;
            cap_rd_a   <= 1'b0;
            cap_rd_b   <= 1'b0;
            cap_we     <= 1'b0;
            cap_rs1    <= '0;
            cap_rs2    <= '0;
            cap_rd     <= '0;
            cap_wdata  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                mem[i] <= INIT_B + 32'(i);
            end
        end else if (prog_mode) begin
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
            cnt        <= '0;
            cap_rd_a   <= 1'b0;
            cap_rd_b   <= 1'b0;
            cap_we     <= 1'b0;
            cap_rs1    <= '0;
            cap_rs2    <= '0;
            cap_rd     <= '0;
            cap_wdata  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                mem[i] <= INIT_B + 32'(i);
            end
        end else begin
            req_ready <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            // One edge after entering RESP the response becomes visible; it drops on the take edge.
            rsp_valid <= (state == RESP) && (next_state == RESP);

            if (load_cnt) begin
                cnt <= CNT_LOAD;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end

            if (accept) begin
                cap_rd_a   <= req_rd_a;
                cap_rd_b   <= req_rd_b;
                cap_we     <= req_we;
                cap_rs1    <= req_rs1;
                cap_rs2    <= req_rs2;
                cap_rd     <= req_rd;
                cap_wdata  <= req_wdata;
                rsp_rdata1 <= '0;
                rsp_rdata2 <= '0;
                rsp_err    <= req_err;
            end

            // Lower-half addresses still burn their stage cycles but never touch the array.
            if ((state == RD_A) && stage_done && cap_rs1[4]) begin
                rsp_rdata1 <= mem[cap_rs1[3:0]];
            end
            if ((state == RD_B) && stage_done && cap_rs2[4]) begin
                rsp_rdata2 <= mem[cap_rs2[3:0]];
            end
            if ((state == WR) && cap_rd[4]) begin
                mem[cap_rd[3:0]] <= cap_wdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_spill_ram.sv
// Directed self-checking bench for reg_spill_ram (RD_LAT=2, INIT_B=16).
module tb_reg_spill_ram;

    logic        CLK;
    logic        RESET_N;
    logic        prog_mode;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd_a;
    logic        req_rd_b;
    logic        req_we;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rd;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata1;
    logic [31:0] rsp_rdata2;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    reg_spill_ram #(
        .RD_LAT(2),
        .INIT_B(32'd16)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .prog_mode (prog_mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd_a  (req_rd_a),
        .req_rd_b  (req_rd_b),
        .req_we    (req_we),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata1(rsp_rdata1),
        .rsp_rdata2(rsp_rdata2),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one request, waits for acceptance, then returns once the DUT presents a response
    // (lat = edges after the accepting edge, -1 on timeout); the response is consumed afterwards.
    task automatic send_req(input logic a, input logic b, input logic w,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] wd,
                            output int lat, output logic [31:0] d1,
                            output logic [31:0] d2, output logic e);
        int k;
        @(negedge CLK);
        req_rd_a = a; req_rd_b = b; req_we = w;
        req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wdata = wd;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        lat = -1; d1 = '1; d2 = '1; e = 1'bx;
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (rsp_valid) begin
            lat = k; d1 = rsp_rdata1; d2 = rsp_rdata2; e = rsp_err;
            rsp_ready = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        int lat; logic [31:0] d1, d2; logic e;
        RESET_N = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            rsp_err !== 1'b0 || rsp_rdata1 !== 32'd0 || rsp_rdata2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b ready=%b err=%b d1=%h d2=%h expected all 0",
                     busy, rsp_valid, req_ready, rsp_err, rsp_rdata1, rsp_rdata2);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        // Start a read/read/write request and reset it while in RD_B.
        @(negedge CLK);
        req_rd_a = 1'b1; req_rd_b = 1'b1; req_we = 1'b1;
        req_rs1 = 5'd17; req_rs2 = 5'd18; req_rd = 5'd20; req_wdata = 32'hAAAA5555;
        req_valid = 1'b1;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy busy=%b expected 1", busy);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort busy=%b valid=%b expected 0 0", busy, rsp_valid);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        send_req(1'b1, 1'b0, 1'b0, 5'd20, 5'd0, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (d1 !== 32'd20 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_x20 data=%h err=%b expected 00000014 0", d1, e);
        end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] d1, d2; logic e;
        send_req(1'b1, 1'b1, 1'b0, 5'd17, 5'd18, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (lat !== 5 || d1 !== 32'd17 || d2 !== 32'd18 || e !== 1'b0) begin
            errors++;
            $display("FAIL latency_two_reads lat=%0d d1=%h d2=%h err=%b expected 5 11 12 0",
                     lat, d1, d2, e);
        end
        send_req(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (lat !== 1 || d1 !== 32'd0 || d2 !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL latency_empty lat=%0d d1=%h d2=%h err=%b expected 1 0 0 0", lat, d1, d2, e);
        end
        send_req(1'b1, 1'b1, 1'b0, 5'd16, 5'd31, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (lat !== 5 || d1 !== 32'd16 || d2 !== 32'd31) begin
            errors++;
            $display("FAIL bounds_x16_x31 lat=%0d d1=%h d2=%h expected 5 10 1f", lat, d1, d2);
        end
        send_req(1'b0, 1'b1, 1'b0, 5'd0, 5'd25, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (lat !== 3 || d1 !== 32'd0 || d2 !== 32'd25) begin
            errors++;
            $display("FAIL rd_b_only lat=%0d d1=%h d2=%h expected 3 0 19", lat, d1, d2);
        end
    endtask

    task automatic test_raw();
        int lat; logic [31:0] d1, d2; logic e;
        send_req(1'b1, 1'b0, 1'b1, 5'd21, 5'd0, 5'd21, 32'hDEADBEEF, lat, d1, d2, e);
        checks++;
        if (lat !== 4 || d1 !== 32'd21 || e !== 1'b0) begin
            errors++;
            $display("FAIL raw_old_data lat=%0d d1=%h err=%b expected 4 15 0", lat, d1, e);
        end
        send_req(1'b1, 1'b1, 1'b0, 5'd21, 5'd21, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL raw_new_data d1=%h d2=%h expected deadbeef deadbeef", d1, d2);
        end
    endtask

    task automatic test_error();
        int lat; logic [31:0] d1, d2; logic e;
        send_req(1'b0, 1'b1, 1'b1, 5'd0, 5'd5, 5'd3, 32'h0BADF00D, lat, d1, d2, e);
        checks++;
        if (lat !== 4 || d2 !== 32'd0 || e !== 1'b1) begin
            errors++;
            $display("FAIL err_flag lat=%0d d2=%h err=%b expected 4 0 1", lat, d2, e);
        end
        send_req(1'b1, 1'b1, 1'b0, 5'd19, 5'd21, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (d1 !== 32'd19 || d2 !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL err_mem_unchanged d1=%h d2=%h err=%b expected 13 deadbeef 0", d1, d2, e);
        end
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge CLK);
        req_rd_a = 1'b1; req_rd_b = 1'b0; req_we = 1'b0;
        req_rs1 = 5'd22; req_rs2 = 5'd0; req_rd = 5'd0; req_wdata = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge CLK);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata1 !== 32'd22 || req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b d1=%h ready=%b busy=%b expected 1 16 0 1",
                         i, rsp_valid, rsp_rdata1, req_ready, busy);
            end
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release valid=%b busy=%b ready=%b expected 0 0 1",
                     rsp_valid, busy, req_ready);
        end
        @(negedge CLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_prog_mode();
        int lat; logic [31:0] d1, d2; logic e;
        int seen;
        @(negedge CLK);
        req_rd_a = 1'b0; req_rd_b = 1'b0; req_we = 1'b1;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd30; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        prog_mode = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL prog_ready cyc=%0d ready=%b expected 0", i, req_ready);
            end
            @(negedge CLK);
        end
        prog_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) seen++;
            @(negedge CLK);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL prog_no_response valid_cycles=%0d expected 0", seen);
        end
        send_req(1'b1, 1'b1, 1'b0, 5'd30, 5'd21, 5'd0, 32'd0, lat, d1, d2, e);
        checks++;
        if (d1 !== 32'd30 || d2 !== 32'd21) begin
            errors++;
            $display("FAIL prog_reinit d1=%h d2=%h expected 1e 15", d1, d2);
        end
    endtask

    initial begin
        prog_mode = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_rd_a = 1'b0; req_rd_b = 1'b0; req_we = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wdata = '0;
        test_reset();
        test_latency();
        test_raw();
        test_error();
        test_backpressure();
        test_prog_mode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
